// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end.
// Owns the architectural PC, issues instruction-memory reads and buffers
// fetched {pc, instr} pairs in a DEPTH-entry FIFO that feeds decode.
// Decode back-pressure (stall_d) and execute redirects (pc_src) are absorbed here.
// Optional feature: define FETCH_PERF_EN to add the perf_fetched / perf_bubbles
// saturating event counters.

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        stall_d,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h00000013;

    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   pcMem    [DEPTH];
    logic [31:0]   instrMem [DEPTH];

    logic          pop;
    logic          push;

    // Handshake terms: decode takes the head unless stalled; a fetch is
    // issued whenever there is (or will be) room and no redirect is pending.
    always_comb begin
        valid_d   = (count_q != '0);
        pop       = valid_d & ~stall_d;
        imem_addr = fetchPc_q;
        imem_req  = rst & ~pc_src & ((count_q < DEPTH_C) | pop);
        push      = imem_req & imem_ready;
    end

    // Head-of-FIFO presentation to decode; a NOP with zero PCs when empty.
    always_comb begin
        instr_d   = NOP;
        pc_d      = '0;
        pcplus4_d = '0;
        if (valid_d) begin
            instr_d   = instrMem[rdPtr_q];
            pc_d      = pcMem[rdPtr_q];
            pcplus4_d = pcMem[rdPtr_q] + 32'd4;
        end
    end

    // Next-state for PC, pointers and occupancy; a redirect flushes the
    // FIFO and overrides any push or pop in the same cycle.
    always_comb begin
        fetchPc_d = fetchPc_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        if (pc_src) begin
            fetchPc_d = {pc_target[31:2], 2'b00};
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
        end else begin
            if (push) begin
                fetchPc_d = fetchPc_q + 32'd4;
                wrPtr_d   = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetchPc_q <= RESET_PC;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr_q]    <= fetchPc_q;
            instrMem[wrPtr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perfFetched_q;
    logic [31:0] perfBubbles_q;

    // Saturating event counters: accepted pops and empty-output cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perfFetched_q <= '0;
            perfBubbles_q <= '0;
        end else begin
            if (pop && !pc_src && (perfFetched_q != 32'hFFFFFFFF)) begin
                perfFetched_q <= perfFetched_q + 32'd1;
            end
            if (!valid_d && (perfBubbles_q != 32'hFFFFFFFF)) begin
                perfBubbles_q <= perfBubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perfFetched_q;
    assign perf_bubbles = perfBubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a
// queue-based reference model of the fetch front end.

module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        stall_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .stall_d    (stall_d),
        .valid_d    (valid_d),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: two fixed words then an address-derived pattern.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0)      return 32'h00500093;
        else if (a == 32'h4) return 32'h00300113;
        else                 return {a[19:0], 12'h093};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    typedef struct {
        logic        rstN;
        logic        src;
        logic [31:0] tgt;
        logic        stall;
        logic        ready;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [31:0] expAddr;
        logic        expReq;
    } vec_t;

    vec_t vecs [20];

    int vectorCount = 0;
    int missCount   = 0;

    // Reference model state: PC plus an ordered list of buffered {pc, instr}.
    logic [31:0] mPc;
    logic [63:0] mQ [$];
    logic [31:0] mFetched;
    logic [31:0] mBubbles;

    function automatic vec_t mkVec(input logic rn, input logic s, input logic [31:0] t,
                                   input logic st, input logic rd, input logic ev,
                                   input logic [31:0] epc, input logic [31:0] ein,
                                   input logic [31:0] ea, input logic er);
        vec_t v;
        v.rstN = rn; v.src = s; v.tgt = t; v.stall = st; v.ready = rd;
        v.expValid = ev; v.expPc = epc; v.expInstr = ein; v.expAddr = ea; v.expReq = er;
        return v;
    endfunction

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [31:0] epc,
                               input logic [31:0] ein, input logic [31:0] ea, input logic er);
        logic [31:0] ep4;
        ep4 = ev ? epc + 32'd4 : 32'h0;
        compareField({tag, " valid_d"},   {31'b0, valid_d},  {31'b0, ev});
        compareField({tag, " pc_d"},      pc_d,      epc);
        compareField({tag, " instr_d"},   instr_d,   ein);
        compareField({tag, " pcplus4_d"}, pcplus4_d, ep4);
        compareField({tag, " imem_addr"}, imem_addr, ea);
        compareField({tag, " imem_req"},  {31'b0, imem_req}, {31'b0, er});
    endtask

    // Drive one cycle's inputs after the falling edge and let them settle.
    task automatic applyStimulus(input logic rn, input logic s, input logic [31:0] t,
                                 input logic st, input logic rd);
        @(negedge clk);
        rst        = rn;
        pc_src     = s;
        pc_target  = t;
        stall_d    = st;
        imem_ready = rd;
        #1;
    endtask

    // Advance the reference model across the rising edge using current inputs.
    task automatic modelEdge();
        logic mValid, mPop, mReq;
        mValid = (mQ.size() != 0);
        mPop   = mValid & ~stall_d;
        mReq   = rst & ~pc_src & ((mQ.size() < DEPTH) | mPop);
        @(posedge clk);
        if (!rst) begin
            mQ.delete();
            mPc      = RESET_PC;
            mFetched = 0;
            mBubbles = 0;
        end else if (pc_src) begin
            mQ.delete();
            mPc = pc_target & 32'hFFFFFFFC;
            if (!mValid && mBubbles != 32'hFFFFFFFF) mBubbles++;
        end else begin
            if (mPop) begin
                void'(mQ.pop_front());
                if (mFetched != 32'hFFFFFFFF) mFetched++;
            end
            if (!mValid && mBubbles != 32'hFFFFFFFF) mBubbles++;
            if (mReq && imem_ready) begin
                mQ.push_back({mPc, memWord(mPc)});
                mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic checkModel(input string tag);
        logic        ev;
        logic [31:0] epc, ein;
        logic        er;
        ev  = (mQ.size() != 0);
        epc = ev ? mQ[0][63:32] : 32'h0;
        ein = ev ? mQ[0][31:0]  : NOP;
        er  = rst & ~pc_src & ((mQ.size() < DEPTH) | (ev & ~stall_d));
        checkOutput(tag, ev, epc, ein, mPc, er);
`ifdef FETCH_PERF_EN
        compareField({tag, " perf_fetched"}, perf_fetched, mFetched);
        compareField({tag, " perf_bubbles"}, perf_bubbles, mBubbles);
`endif
    endtask

    initial begin
        rst = 1'b0; pc_src = 1'b0; pc_target = '0; stall_d = 1'b0; imem_ready = 1'b1;
        mPc = RESET_PC; mFetched = 0; mBubbles = 0;

        vecs[0]  = mkVec(1, 0, 32'h0,  0, 1, 0, 32'h0,  NOP,            32'h00, 1);
        vecs[1]  = mkVec(1, 0, 32'h0,  0, 1, 1, 32'h0,  32'h00500093,   32'h04, 1);
        vecs[2]  = mkVec(1, 0, 32'h0,  1, 1, 1, 32'h4,  32'h00300113,   32'h08, 1);
        vecs[3]  = mkVec(1, 0, 32'h0,  1, 1, 1, 32'h4,  32'h00300113,   32'h0C, 0);
        vecs[4]  = mkVec(1, 0, 32'h0,  1, 1, 1, 32'h4,  32'h00300113,   32'h0C, 0);
        vecs[5]  = mkVec(1, 0, 32'h0,  1, 1, 1, 32'h4,  32'h00300113,   32'h0C, 0);
        vecs[6]  = mkVec(1, 0, 32'h0,  0, 1, 1, 32'h4,  32'h00300113,   32'h0C, 1);
        vecs[7]  = mkVec(1, 0, 32'h0,  0, 1, 1, 32'h8,  memWord(32'h8), 32'h10, 1);
        vecs[8]  = mkVec(1, 1, 32'h40, 0, 1, 1, 32'hC,  memWord(32'hC), 32'h14, 0);
        vecs[9]  = mkVec(1, 0, 32'h0,  0, 1, 0, 32'h0,  NOP,            32'h40, 1);
        vecs[10] = mkVec(1, 0, 32'h0,  0, 1, 1, 32'h40, memWord(32'h40), 32'h44, 1);
        vecs[11] = mkVec(1, 1, 32'h46, 1, 1, 1, 32'h44, memWord(32'h44), 32'h48, 0);
        vecs[12] = mkVec(1, 0, 32'h0,  1, 1, 0, 32'h0,  NOP,            32'h44, 1);
        vecs[13] = mkVec(1, 0, 32'h0,  0, 0, 1, 32'h44, memWord(32'h44), 32'h48, 1);
        vecs[14] = mkVec(1, 0, 32'h0,  0, 0, 0, 32'h0,  NOP,            32'h48, 1);
        vecs[15] = mkVec(1, 0, 32'h0,  0, 1, 0, 32'h0,  NOP,            32'h48, 1);
        vecs[16] = mkVec(1, 0, 32'h0,  0, 1, 1, 32'h48, memWord(32'h48), 32'h4C, 1);
        vecs[17] = mkVec(1, 0, 32'h0,  1, 1, 1, 32'h4C, memWord(32'h4C), 32'h50, 1);
        vecs[18] = mkVec(0, 0, 32'h0,  1, 1, 1, 32'h4C, memWord(32'h4C), 32'h54, 0);
        vecs[19] = mkVec(1, 0, 32'h0,  0, 1, 0, 32'h0,  NOP,            32'h00, 1);

        // Two reset cycles bring the DUT and the model to a known state.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 32'h0, 0, 1);
            modelEdge();
        end

        // Directed table: start-up, stall fill, redirects, ready gaps, mid-stream reset.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].src, vecs[i].tgt, vecs[i].stall, vecs[i].ready);
            checkOutput($sformatf("row%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expInstr, vecs[i].expAddr, vecs[i].expReq);
            modelEdge();
        end

        // Hand sequence: redirect near the top of memory to exercise PC wrap.
        applyStimulus(1, 1, 32'hFFFFFFFB, 0, 1);
        checkModel("wrapRedirect");
        modelEdge();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 32'h0, 0, 1);
            checkModel($sformatf("wrap%0d", i));
            modelEdge();
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic        rn, s, st, rd;
            logic [31:0] t;
            rn = ($urandom_range(0, 39) != 0);
            s  = ($urandom_range(0, 7) == 0);
            t  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF4 + $urandom_range(0, 11) : $urandom;
            st = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 3) != 0);
            applyStimulus(rn, s, t, st, rd);
            checkModel($sformatf("rnd%0d", i));
            modelEdge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
